// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the two requesters, the arbiter and the register file.
// master = requester/register-file side, slave = arbiter side.
interface regfile_write_arbiter_if #(
    parameter int p_data_nbits  = 1,
    parameter int p_num_entries = 2
);
    localparam int c_addr_nbits = $clog2(p_num_entries);

    logic                    req0_val;
    logic                    req0_rdy;
    logic [c_addr_nbits-1:0] req0_addr;
    logic [p_data_nbits-1:0] req0_data;
    logic                    req1_val;
    logic                    req1_rdy;
    logic [c_addr_nbits-1:0] req1_addr;
    logic [p_data_nbits-1:0] req1_data;
    logic                    rf_write_en;
    logic [c_addr_nbits-1:0] rf_write_addr;
    logic [p_data_nbits-1:0] rf_write_data;
    logic                    init_done;

    modport master (
        output req0_val, req0_addr, req0_data,
        output req1_val, req1_addr, req1_data,
        input  req0_rdy, req1_rdy,
        input  rf_write_en, rf_write_addr, rf_write_data, init_done
    );

    modport slave (
        input  req0_val, req0_addr, req0_data,
        input  req1_val, req1_addr, req1_data,
        output req0_rdy, req1_rdy,
        output rf_write_en, rf_write_addr, rf_write_data, init_done
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single write port of a 1r1w register file.
// Optional post-reset init sweep (writes p_init_value into every entry) is
// enabled by defining REGFILE_WRITE_ARBITER_INIT_EN; without it the block
// comes out of reset ready to grant.
module regfile_write_arbiter #(
    parameter int p_data_nbits  = 1,
    parameter int p_num_entries = 2,
    parameter int p_init_value  = 0
) (
    input  logic clk,
    input  logic reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int c_addr_nbits = $clog2(p_num_entries);

    logic prio_q, prio_d;
    logic in_run;
    logic gnt0, gnt1;

`ifdef REGFILE_WRITE_ARBITER_INIT_EN
    localparam logic [p_data_nbits-1:0] c_init_val  = p_data_nbits'(p_init_value);
    localparam logic [c_addr_nbits-1:0] c_last_addr = c_addr_nbits'(p_num_entries - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t                  state_q, state_d;
    logic [c_addr_nbits-1:0] cnt_q, cnt_d;

    assign in_run = (state_q == ST_RUN);

    // Sweep sequencing: step the address each cycle, stop on the last entry
    // so cnt never wraps for non-power-of-2 sizes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (cnt_q == c_last_addr) state_d = ST_RUN;
            else                      cnt_d   = cnt_q + 1'b1;
        end
    end

    // FSM and sweep counter; reset restarts the sweep from entry 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign in_run = 1'b1;
`endif

    // Grant: a lone requester always wins; on contention prio picks the winner.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (in_run) begin
            gnt0 = bus.req0_val & (~bus.req1_val | ~prio_q);
            gnt1 = bus.req1_val & (~bus.req0_val |  prio_q);
        end
    end

    // Priority flips to the requester that did not just win; holds when idle.
    always_comb begin
        prio_d = prio_q;
        if (gnt0)      prio_d = 1'b1;
        else if (gnt1) prio_d = 1'b0;
    end

    // Priority register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prio_q <= 1'b0;
        else        prio_q <= prio_d;
    end

    // Write-port mux: sweep value while initialising, else the granted request.
    always_comb begin
        bus.req0_rdy      = gnt0;
        bus.req1_rdy      = gnt1;
        bus.init_done     = in_run;
        bus.rf_write_en   = gnt0 | gnt1;
        bus.rf_write_addr = '0;
        bus.rf_write_data = '0;
        if (gnt0) begin
            bus.rf_write_addr = bus.req0_addr;
            bus.rf_write_data = bus.req0_data;
        end else if (gnt1) begin
            bus.rf_write_addr = bus.req1_addr;
            bus.rf_write_data = bus.req1_data;
        end
`ifdef REGFILE_WRITE_ARBITER_INIT_EN
        if (!in_run) begin
            bus.rf_write_en   = 1'b1;
            bus.rf_write_addr = cnt_q;
            bus.rf_write_data = c_init_val;
        end
`endif
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a behavioural model.
module tb_regfile_write_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AW = 2;
    localparam logic [W-1:0] INITV = 8'h5A;
`ifdef REGFILE_WRITE_ARBITER_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   chk_en      = 1'b0;

    regfile_write_arbiter_if #(.p_data_nbits(W), .p_num_entries(N)) bus ();

    regfile_write_arbiter #(
        .p_data_nbits (W),
        .p_num_entries(N),
        .p_init_value (int'(INITV))
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // The register file the arbiter drives.
    logic [W-1:0] rf_q [N];
    always @(posedge clk)
        if (bus.rf_write_en === 1'b1) rf_q[bus.rf_write_addr] <= bus.rf_write_data;

    // Behavioural model: cycles of sweep left, who won last, expected contents.
    int           m_init_left = 0;
    int           m_last      = -1;
    logic [W-1:0] m_mem [N];
    bit           m_wr  [N];

    function automatic int winner(logic v0, logic v1, int last);
        if (v0 && v1) return (last == 0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_init_left <= INIT_EN ? N : 0;
            m_last      <= -1;
        end else if (m_init_left > 0) begin
            m_mem[N-m_init_left] <= INITV;
            m_wr[N-m_init_left]  <= 1'b1;
            m_init_left          <= m_init_left - 1;
        end else if (winner(bus.req0_val, bus.req1_val, m_last) == 0) begin
            m_mem[bus.req0_addr] <= bus.req0_data;
            m_wr[bus.req0_addr]  <= 1'b1;
            m_last               <= 0;
        end else if (winner(bus.req0_val, bus.req1_val, m_last) == 1) begin
            m_mem[bus.req1_addr] <= bus.req1_data;
            m_wr[bus.req1_addr]  <= 1'b1;
            m_last               <= 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    logic          e_en, e_r0, e_r1, e_done;
    logic [AW-1:0] e_a;
    logic [W-1:0]  e_d;
    int            e_w;
    always @(negedge clk) begin
        if (chk_en && (reset || INIT_EN)) begin
            if (m_init_left > 0) begin
                e_en = 1'b1; e_r0 = 1'b0; e_r1 = 1'b0; e_done = 1'b0;
                e_a  = AW'(N - m_init_left);
                e_d  = INITV;
            end else begin
                e_w    = winner(bus.req0_val, bus.req1_val, m_last);
                e_done = 1'b1;
                e_r0   = (e_w == 0);
                e_r1   = (e_w == 1);
                e_en   = (e_w >= 0);
                e_a    = (e_w == 0) ? bus.req0_addr : (e_w == 1) ? bus.req1_addr : '0;
                e_d    = (e_w == 0) ? bus.req0_data : (e_w == 1) ? bus.req1_data : '0;
            end
            chk("m_init_done", bus.init_done,     e_done);
            chk("m_req0_rdy",  bus.req0_rdy,      e_r0);
            chk("m_req1_rdy",  bus.req1_rdy,      e_r1);
            chk("m_wr_en",     bus.rf_write_en,   e_en);
            chk("m_wr_addr",   bus.rf_write_addr, e_a);
            chk("m_wr_data",   bus.rf_write_data, e_d);
        end
    end

    logic g0, g1;

    initial begin
        bus.req0_val = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_val = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        #1 reset = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

`ifdef REGFILE_WRITE_ARBITER_INIT_EN
        // Sweep: addr 0..3, data 0x5A, nothing granted, not done.
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("sweep_en",   bus.rf_write_en, 1);
            chk("sweep_addr", bus.rf_write_addr, i);
            chk("sweep_data", bus.rf_write_data, 8'h5A);
            chk("sweep_done", bus.init_done, 0);
            chk("sweep_rdy",  {bus.req0_rdy, bus.req1_rdy}, 0);
        end
        @(posedge clk); #1;
`else
        // No sweep: first cycle already accepts a request.
        bus.req0_val = 1'b1; bus.req0_addr = 2'd1; bus.req0_data = 8'h33;
        @(negedge clk);
        chk("noinit_done", bus.init_done, 1);
        chk("noinit_rdy0", bus.req0_rdy, 1);
        chk("noinit_addr", bus.rf_write_addr, 1);
        chk("noinit_data", bus.rf_write_data, 8'h33);
        @(posedge clk); #1 bus.req0_val = 1'b0;
        @(negedge clk);
        chk("noinit_rd1", rf_q[1], 8'h33);
        @(posedge clk); #1;
`endif

        // Lone requester 1.
        bus.req1_val = 1'b1; bus.req1_addr = 2'd2; bus.req1_data = 8'hAB;
        @(negedge clk);
        chk("r1_done", bus.init_done, 1);
        chk("r1_rdy1", bus.req1_rdy, 1);
        chk("r1_rdy0", bus.req0_rdy, 0);
        chk("r1_en",   bus.rf_write_en, 1);
        chk("r1_addr", bus.rf_write_addr, 2);
        chk("r1_data", bus.rf_write_data, 8'hAB);
        @(posedge clk); #1 bus.req1_val = 1'b0;
        @(negedge clk);
        chk("r1_read", rf_q[2], 8'hAB);
        chk("idle_en", bus.rf_write_en, 0);

        // Contention on one address: grants 0,1,0,1.
        @(posedge clk); #1;
        bus.req0_val = 1'b1; bus.req0_addr = 2'd3;
        bus.req1_val = 1'b1; bus.req1_addr = 2'd3;
        for (int k = 0; k < 4; k++) begin
            bus.req0_data = 8'h10 + 8'(k);
            bus.req1_data = 8'h20 + 8'(k);
            @(negedge clk);
            chk("rr_rdy0", bus.req0_rdy, (k % 2 == 0));
            chk("rr_rdy1", bus.req1_rdy, (k % 2 == 1));
            @(posedge clk); #1;
        end
        bus.req0_val = 1'b0; bus.req1_val = 1'b0;
        @(negedge clk);
        chk("rr_last", rf_q[3], 8'h23);

        // Lone requester 1 right after its own grant is never stalled.
        @(posedge clk); #1 bus.req1_val = 1'b1; bus.req1_addr = 2'd0;
        for (int k = 0; k < 3; k++) begin
            bus.req1_data = 8'hC0 + 8'(k);
            @(negedge clk);
            chk("lone_rdy1", bus.req1_rdy, 1);
            @(posedge clk); #1;
        end
        bus.req1_val = 1'b0;

        // Reset in RUN after a requester-0 grant (prio now favours 1).
        bus.req0_val = 1'b1; bus.req0_addr = 2'd1; bus.req0_data = 8'h44;
        @(posedge clk); #1 bus.req0_data = 8'h45;
`ifdef REGFILE_WRITE_ARBITER_INIT_EN
        #3 reset = 1'b0;
        #1;
        chk("rst_rdy0", bus.req0_rdy, 0);
        chk("rst_done", bus.init_done, 0);
        chk("rst_addr", bus.rf_write_addr, 0);
        @(posedge clk); #1 reset = 1'b1;
        bus.req1_val = 1'b1; bus.req1_addr = 2'd2; bus.req1_data = 8'h55;
        repeat (N) @(posedge clk);
        #1;
`else
        bus.req0_val = 1'b0;
        #3 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        bus.req0_val = 1'b1;
        bus.req1_val = 1'b1; bus.req1_addr = 2'd2; bus.req1_data = 8'h55;
`endif
        @(negedge clk);
        chk("post_rst_rdy0", bus.req0_rdy, 1);
        chk("post_rst_rdy1", bus.req1_rdy, 0);
        @(posedge clk); #1 bus.req0_val = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy1b", bus.req1_rdy, 1);
        @(posedge clk); #1 bus.req1_val = 1'b0;

`ifdef REGFILE_WRITE_ARBITER_INIT_EN
        // Reset mid-sweep at cnt=2 restarts from entry 0.
        reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk("midsweep_addr2", bus.rf_write_addr, 2);
        reset = 1'b0;
        #1;
        chk("midsweep_addr0", bus.rf_write_addr, 0);
        chk("midsweep_en",    bus.rf_write_en, 1);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("restart_addr", bus.rf_write_addr, 0);
        repeat (N) @(posedge clk);
        #1;
`endif

        // Randomized traffic; a pending request is held until accepted.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            g0 = bus.req0_rdy; g1 = bus.req1_rdy;
            @(posedge clk); #1;
            if (!bus.req0_val || g0) begin
                bus.req0_val  = ($urandom_range(0, 2) != 0);
                bus.req0_addr = AW'($urandom_range(0, N-1));
                bus.req0_data = W'($urandom);
            end
            if (!bus.req1_val || g1) begin
                bus.req1_val  = ($urandom_range(0, 2) != 0);
                bus.req1_addr = AW'($urandom_range(0, N-1));
                bus.req1_data = W'($urandom);
            end
        end
        bus.req0_val = 1'b0; bus.req1_val = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        for (int i = 0; i < N; i++)
            if (m_wr[i]) chk("rf_contents", rf_q[i], m_mem[i]);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
